// File: rtl/brch_resolve_unit.sv
// Resolves beq/bne in ID against the IF-stage prediction, trains the predictor,
// and issues a one-cycle flush plus fetch redirect on a mispredict.
module brch_resolve_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              brch_instr_detectd_IF,
  input  logic              predict_br_taken,
  input  logic [DATA_W-1:0] if_pc_plus4,
  input  logic [DATA_W-1:0] if_br_target,
  input  logic              if_id_stall,
  input  logic              brch_instr_detectd_ID,
  input  logic              brch_is_bne_ID,
  input  logic [DATA_W-1:0] rs_val_ID,
  input  logic [DATA_W-1:0] rt_val_ID,
  input  logic              brch_hazard_stall,
  output logic              actual_brch_result,
  output logic              brch_update_vld,
  output logic              mispredict_flush,
  output logic              redirect_vld,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  mispred_count,
  output logic              state_dbg
);

  // Handshake: brch_update_vld is a single-cycle strobe with no ready; the
  // predictor must sample actual_brch_result on the same posedge it is high.
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              trk_pred;
  logic [DATA_W-1:0] trk_pc4, trk_tgt, redir_pc;
  logic              res, eq, mispredict;

  assign state_dbg = state;

  always_comb begin
    state_nxt          = state;
    res                = brch_instr_detectd_ID & ~brch_hazard_stall & (state == RUN);
    eq                 = (rs_val_ID == rt_val_ID);
    actual_brch_result = 1'b0;
    brch_update_vld    = res;
    mispredict_flush   = 1'b0;
    redirect_vld       = 1'b0;
    redirect_pc        = '0;
    if (res) actual_brch_result = brch_is_bne_ID ? ~eq : eq;
    mispredict = res & (actual_brch_result != trk_pred);
    case (state)
      RUN:   if (mispredict) state_nxt = FLUSH;
      FLUSH: begin
        state_nxt        = RUN;
        mispredict_flush = 1'b1;
        redirect_vld     = 1'b1;
        redirect_pc      = redir_pc;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Tracking register follows IF/ID; cleared in FLUSH since IF/ID holds a wrong-path instruction.
  always_ff @(posedge clk) begin
    if (!rst_n || state == FLUSH) begin
      trk_pred <= 1'b0;
      trk_pc4  <= '0;
      trk_tgt  <= '0;
    end else if (!if_id_stall && !brch_hazard_stall) begin
      trk_pred <= predict_br_taken & brch_instr_detectd_IF;
      trk_pc4  <= if_pc_plus4;
      trk_tgt  <= if_br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redir_pc <= '0;
    end else if (mispredict) begin
      redir_pc <= actual_brch_result ? trk_tgt : trk_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (res && br_count != '1) br_count <= br_count + 1'b1;
      if (mispredict && mispred_count != '1) mispred_count <= mispred_count + 1'b1;
    end
  end

endmodule
